// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, optional first-word-fall-through read, and overflow/underflow pulses.
module sync_fifo_prog #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             w_valid,
  output logic             wfull,
  output logic             walmost_full,
  output logic [DSIZE-1:0] rdata,
  input  logic             r_valid,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ASIZE:0] DEPTH = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF_L  = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AE_L  = AE_LEVEL[ASIZE:0];

  logic [DSIZE-1:0] mem [2**ASIZE];

  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_next, rptr_next, count_next;
  logic [ASIZE-1:0] waddr, raddr;
  logic             we, re;

  assign waddr = wptr[ASIZE-1:0];
  assign raddr = rptr[ASIZE-1:0];
  assign we    = w_valid & ~wfull;
  assign re    = r_valid & ~rempty;

  // Next pointers; occupancy is the pointer difference, which moves +1/-1/0
  // exactly as the accepted write/read combination dictates.
  always_comb begin
    wptr_next  = wptr;
    rptr_next  = rptr;
    if (we) wptr_next = wptr + 1'b1;
    if (re) rptr_next = rptr + 1'b1;
    count_next = wptr_next - rptr_next;
  end

  // Pointers, count, status flags and error pulses, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      wptr          <= wptr_next;
      rptr          <= rptr_next;
      count         <= count_next;
      wfull         <= (count_next == DEPTH);
      rempty        <= (count_next == '0);
      walmost_full  <= (count_next >= AF_L);
      ralmost_empty <= (count_next <= AE_L);
      overflow      <= w_valid & wfull;
      underflow     <= r_valid & rempty;
    end
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly whenever the FIFO holds data.
      assign rdata = rempty ? '0 : mem[raddr];
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      // Registered read: load the head word on each accepted pop, else hold.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO for paths where producer and consumer share one clock, so no pointer synchronisers are needed. It is the successor to the dual-clock FIFO top. It adds:
- an occupancy count
- programmable almost-full and almost-empty flags
- a selectable first-word-fall-through (FWFT) read mode
- overflow and underflow error pulses

Storage is 2**ASIZE words of DSIZE bits.

Parameters:
DSIZE, 8, data word width in bits
ASIZE, 4, address width; depth = 2**ASIZE (16)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_LEVEL, 14, walmost_full asserts when count >= AF_LEVEL (legal range 1..2**ASIZE)
AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL (legal range 0..2**ASIZE-1)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
wdata  input  DSIZE  write data
w_valid  input  1  write request
wfull  output  1  FIFO full
walmost_full  output  1  count >= AF_LEVEL
rdata  output  DSIZE  read data
r_valid  input  1  read request (pop)
rempty  output  1  FIFO empty
ralmost_empty  output  1  count <= AE_LEVEL
count  output  ASIZE+1  current occupancy, 0..2**ASIZE
overflow  output  1  one-cycle pulse: write attempted while full
underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset is asynchronous and active-high. It is fixed by design: one clock, clk; one reset, rst.
- While rst is high, outputs and state hold these values:
  - write and read pointers = 0, count = 0
  - rempty = 1, wfull = 0, ralmost_empty = 1, walmost_full = 0 (assuming AF_LEVEL > 0)
  - rdata = 0, overflow = 0, underflow = 0
  - memory contents are not reset
- Asserting rst mid-operation discards all stored data immediately. The first write after rst deasserts lands at address 0.
- Accept conditions:
  - write accepted (we) = w_valid & ~wfull
  - read accepted (re) = r_valid & ~rempty
  - Flags are those registered at the current edge; there is no same-cycle pass-through.
- Pointers are ASIZE+1 bits, plain binary. The address is the low ASIZE bits and wraps 2**ASIZE-1 -> 0; the MSB toggles on each wrap.
- Count update:
  - +1 on we only
  - -1 on re only
  - unchanged when both or neither occur
- All status outputs (wfull, rempty, walmost_full, ralmost_empty, count) are registers. They reflect the post-edge state, computed from the next count:
  - wfull = (count == 2**ASIZE)
  - rempty = (count == 0)
- When full, we and re occur in the same cycle: write rejected, read accepted, count -> 2**ASIZE-1.
- When empty, we and re occur in the same cycle: read rejected, write accepted, count -> 1.
- Otherwise, simultaneous we and re both proceed and count is unchanged.
- Standard mode (FWFT=0):
  - rdata is registered and loads mem[raddr] on the edge where re = 1.
  - Data is valid one cycle after the r_valid edge.
  - rdata holds its value when there is no re.
- FWFT mode (FWFT=1):
  - rdata presents the head word, mem[raddr], whenever rempty = 0. r_valid pops it, and the next word appears after that edge.
  - First-write latency: the write edge sets rempty = 0, and rdata is valid in that same following cycle.
  - rdata is don't-care while rempty = 1.
- Error pulses:
  - overflow = registered (w_valid & wfull); high for exactly one cycle per offending request cycle.
  - underflow = registered (r_valid & rempty); same one-cycle rule.
  - State is never corrupted by a rejected request.
- Thresholds are static parameters. Illegal AF_LEVEL / AE_LEVEL values are out of scope and need not be checked.

Test Plan:
- Reset and flags: rst high then low -> rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, count=0. Assert rst after 5 writes -> count=0 and rempty=1 immediately, without waiting for clk.
- Fill and overflow: write 0x00..0x0F, then one more write with w_valid=1 -> walmost_full rises when count=14, wfull rises when count=16, overflow pulses exactly 1 cycle, 0xAA is not stored.
- Drain in standard mode (FWFT=0): after the fill, pop 16 words -> rdata = 0x00..0x0F, each one cycle after its r_valid edge. ralmost_empty rises at count=2, rempty at count=0. A 17th pop -> underflow pulses 1 cycle.
- Wrap-around: 10 writes, 10 reads, then 12 writes and 12 reads -> data order preserved across the 15 -> 0 address wrap; count never exceeds 12.
- Simultaneous events:
  - at full, w_valid=r_valid=1 -> count 16 -> 15, no overflow of stored data
  - at empty, both requests -> count 0 -> 1, underflow pulses
  - at count=7, both requests -> count stays 7
- FWFT mode (FWFT=1): single write 0x5A -> next cycle rempty=0 and rdata=0x5A with no r_valid. Pop -> rempty=1. Then back-to-back pops of 3 words show each word before its pop edge.
